set_time_keys: RTL



---
 rtl/set_time_keys.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/set_time_keys.sv
// Alarm-setting keys: per-key synchroniser, debounce and press/auto-repeat FSM
// driving packed-BCD Set_Hr / Set_Min registers with one-cycle update strobes.

module set_time_keys_chan #(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned REPEAT_DELAY    = 500,
   parameter int unsigned REPEAT_RATE     = 100
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_fire
);

   localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMAX);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   logic          r_sync1, r_sync2, r_db;
   logic [DW-1:0] r_dcnt;
   state_t        r_state, w_state_nxt;
   logic [RW-1:0] r_rcnt, w_rcnt_nxt;
   logic          w_fire;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_dcnt  <= '0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_db) begin
            r_dcnt <= '0;
         end else if (r_dcnt == DB_LAST) begin
            r_db   <= r_sync2;
            r_dcnt <= '0;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_rcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rcnt  <= w_rcnt_nxt;
      end
   end

   // A low debounced level always wins over a terminal count in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_fire      = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_db) begin
               w_fire      = 1'b1;
               w_rcnt_nxt  = '0;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (!r_db) begin
               w_state_nxt = IDLE;
               w_rcnt_nxt  = '0;
            end else if (r_rcnt == DELAY_LAST) begin
               w_fire      = 1'b1;
               w_rcnt_nxt  = '0;
               w_state_nxt = REPEAT;
            end else begin
               w_rcnt_nxt  = r_rcnt + 1'b1;
            end
         end
         REPEAT: begin
            if (!r_db) begin
               w_state_nxt = IDLE;
               w_rcnt_nxt  = '0;
            end else if (r_rcnt == RATE_LAST) begin
               w_fire      = 1'b1;
               w_rcnt_nxt  = '0;
            end else begin
               w_rcnt_nxt  = r_rcnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
         end
      endcase
   end

   assign o_fire = w_fire;

endmodule

module set_time_keys #(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned REPEAT_DELAY    = 500,
   parameter int unsigned REPEAT_RATE     = 100
) (
   input  logic       CP,
   input  logic       nCR,
   input  logic       SetMinkey,
   input  logic       SetHrkey,
   output logic [7:0] Set_Hr,
   output logic [7:0] Set_Min,
   output logic       MinPulse,
   output logic       HrPulse
);

   logic       w_min_fire, w_hr_fire;
   logic [7:0] w_min_inc, w_hr_inc;
   logic [7:0] r_set_hr, r_set_min;
   logic       r_min_pulse, r_hr_pulse;

   set_time_keys_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_min_key (
      .i_clk  (CP),
      .i_rst_n(nCR),
      .i_key  (SetMinkey),
      .o_fire (w_min_fire)
   );

   set_time_keys_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_hr_key (
      .i_clk  (CP),
      .i_rst_n(nCR),
      .i_key  (SetHrkey),
      .o_fire (w_hr_fire)
   );

   // Minutes wrap 59 -> 00 with no carry into hours while setting
   always_comb begin
      w_min_inc = r_set_min;
      if (r_set_min[3:0] < 4'd9) begin
         w_min_inc[3:0] = r_set_min[3:0] + 4'd1;
      end else if (r_set_min[3:0] == 4'd9) begin
         w_min_inc[3:0] = 4'd0;
         w_min_inc[7:4] = (r_set_min[7:4] >= 4'd5) ? 4'd0 : r_set_min[7:4] + 4'd1;
      end
   end

   always_comb begin
      w_hr_inc = r_set_hr;
      if (r_set_hr == 8'h23) begin
         w_hr_inc = 8'h00;
      end else if (r_set_hr[3:0] < 4'd9) begin
         w_hr_inc[3:0] = r_set_hr[3:0] + 4'd1;
      end else if (r_set_hr[3:0] == 4'd9 && r_set_hr[7:4] < 4'd2) begin
         w_hr_inc[3:0] = 4'd0;
         w_hr_inc[7:4] = r_set_hr[7:4] + 4'd1;
      end
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         r_set_hr    <= 8'h00;
         r_set_min   <= 8'h00;
         r_min_pulse <= 1'b0;
         r_hr_pulse  <= 1'b0;
      end else begin
         r_min_pulse <= w_min_fire;
         r_hr_pulse  <= w_hr_fire;
         if (w_min_fire) r_set_min <= w_min_inc;
         if (w_hr_fire)  r_set_hr  <= w_hr_inc;
      end
   end

   assign Set_Hr   = r_set_hr;
   assign Set_Min  = r_set_min;
   assign MinPulse = r_min_pulse;
   assign HrPulse  = r_hr_pulse;

endmodule
